// File: rtl/ultrasonic_ranger_core_pkg.sv
// Shared types and constants for the HC-SR04 ranging engine.
package ultrasonic_pkg;

   typedef enum logic [2:0] {
      IDLE,
      TRIG,
      WAIT_RISE,
      MEASURE,
      HOLDOFF
   } state_t;

   localparam int unsigned CM_RECIP = 1130;
   localparam int unsigned CM_SHIFT = 16;
   localparam logic [9:0]  DIST_OOR = 10'd1023;

endpackage

// File: rtl/us_tick_gen.sv
// Microsecond tick divider with a restart input.
module us_tick_gen #(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000
) (
   input  logic ACLK,
   input  logic ARESETN,
   input  logic clr,
   output logic tick
);

   localparam int unsigned DIV = CLK_FREQ_HZ / 1_000_000;
   localparam int unsigned W   = (DIV > 1) ? $clog2(DIV) : 1;
   localparam logic [W-1:0] LAST = W'(DIV - 1);
   localparam logic [W-1:0] LOAD = (DIV > 1) ? W'(1) : W'(0);

   logic [W-1:0] r_cnt;

   // The clr cycle counts as cycle 0 of the new period.
   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_cnt <= '0;
      end else if (clr) begin
         r_cnt <= LOAD;
      end else if (r_cnt == LAST) begin
         r_cnt <= '0;
      end else begin
         r_cnt <= r_cnt + 1'b1;
      end
   end

   assign tick = ~clr & (r_cnt == LAST);

endmodule

// File: rtl/ultrasonic_ranger_core.sv
// HC-SR04 trigger/echo timing engine with cm conversion.
module ultrasonic_ranger_core
   import ultrasonic_pkg::*;
#(
   parameter int unsigned CLK_FREQ_HZ = 100_000_000,
   parameter int unsigned TRIG_US     = 10,
   parameter int unsigned TIMEOUT_US  = 25000,
   parameter int unsigned HOLDOFF_US  = 10000
) (
   input  logic        ACLK,
   input  logic        ARESETN,
   input  logic        start,
   input  logic        auto_en,
   input  logic        echo,
   output logic        trig,
   output logic        busy,
   output logic        valid,
   output logic        timeout,
   output logic [15:0] echo_us,
   output logic [9:0]  distance_cm,
   output logic [15:0] meas_count
);

   localparam logic [15:0] TO_LIM = 16'(TIMEOUT_US);
   localparam logic [15:0] TR_LIM = 16'(TRIG_US);
   localparam logic [15:0] HO_LIM = 16'(HOLDOFF_US);

   state_t      r_state;
   logic [15:0] r_cnt;
   logic        r_clr;
   logic        r_trig;
   logic        r_busy;
   logic        r_sync1;
   logic        r_sync2;
   logic        r_echo_d;
   logic        r_valid;
   logic        r_timeout;
   logic [15:0] r_echo_us;
   logic [9:0]  r_dist;
   logic [15:0] r_meas_cnt;

   logic        w_tick;
   logic        w_rise;
   logic        w_fall;
   logic        w_ok;
   logic        w_to;
   logic [15:0] w_cnt_nx;
   logic [26:0] w_prod;
   logic [9:0]  w_dist;

   us_tick_gen #(
      .CLK_FREQ_HZ(CLK_FREQ_HZ)
   ) u_tick (
      .ACLK   (ACLK),
      .ARESETN(ARESETN),
      .clr    (r_clr),
      .tick   (w_tick)
   );

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_sync1  <= 1'b0;
         r_sync2  <= 1'b0;
         r_echo_d <= 1'b0;
      end else begin
         r_sync1  <= echo;
         r_sync2  <= r_sync1;
         r_echo_d <= r_sync2;
      end
   end

   assign w_rise   = r_sync2 & ~r_echo_d;
   assign w_fall   = ~r_sync2 & r_echo_d;
   assign w_cnt_nx = r_cnt + 16'(w_tick);
   assign w_prod   = 27'(w_cnt_nx) * 27'(CM_RECIP);
   assign w_dist   = 10'(w_prod >> CM_SHIFT);

   // A falling edge on the limiting tick still counts as a normal result.
   assign w_ok = (r_state == MEASURE) & w_fall;
   assign w_to = (w_cnt_nx == TO_LIM) &
                 (((r_state == WAIT_RISE) & ~w_rise) |
                  ((r_state == MEASURE) & ~w_fall));

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_state <= IDLE;
         r_cnt   <= '0;
         r_clr   <= 1'b0;
         r_trig  <= 1'b0;
         r_busy  <= 1'b0;
      end else begin
         r_clr <= 1'b0;
         unique case (r_state)
            IDLE: begin
               if (start | auto_en) begin
                  r_state <= TRIG;
                  r_trig  <= 1'b1;
                  r_busy  <= 1'b1;
                  r_clr   <= 1'b1;
                  r_cnt   <= '0;
               end
            end
            TRIG: begin
               if (w_cnt_nx == TR_LIM) begin
                  r_state <= WAIT_RISE;
                  r_trig  <= 1'b0;
                  r_clr   <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_nx;
               end
            end
            WAIT_RISE, MEASURE: begin
               if (w_ok | w_to) begin
                  r_state <= HOLDOFF;
                  r_clr   <= 1'b1;
                  r_cnt   <= '0;
               end else if (w_rise & (r_state == WAIT_RISE)) begin
                  r_state <= MEASURE;
                  r_clr   <= 1'b1;
                  r_cnt   <= '0;
               end else begin
                  r_cnt <= w_cnt_nx;
               end
            end
            HOLDOFF: begin
               if (w_cnt_nx == HO_LIM) begin
                  r_cnt <= '0;
                  if (auto_en) begin
                     r_state <= TRIG;
                     r_trig  <= 1'b1;
                     r_clr   <= 1'b1;
                  end else begin
                     r_state <= IDLE;
                     r_busy  <= 1'b0;
                  end
               end else begin
                  r_cnt <= w_cnt_nx;
               end
            end
            default: r_state <= IDLE;
         endcase
      end
   end

   always_ff @(posedge ACLK or negedge ARESETN) begin
      if (!ARESETN) begin
         r_valid    <= 1'b0;
         r_timeout  <= 1'b0;
         r_echo_us  <= '0;
         r_dist     <= '0;
         r_meas_cnt <= '0;
      end else begin
         r_valid <= w_ok | w_to;
         if (w_ok | w_to) begin
            r_meas_cnt <= r_meas_cnt + 1'b1;
         end
         if (w_ok) begin
            r_echo_us <= w_cnt_nx;
            r_dist    <= w_dist;
            r_timeout <= 1'b0;
         end else if (w_to) begin
            r_echo_us <= TO_LIM;
            r_dist    <= DIST_OOR;
            r_timeout <= 1'b1;
         end
      end
   end

   assign trig        = r_trig;
   assign busy        = r_busy;
   assign valid       = r_valid;
   assign timeout     = r_timeout;
   assign echo_us     = r_echo_us;
   assign distance_cm = r_dist;
   assign meas_count  = r_meas_cnt;

endmodule

// File: tb/tb_ultrasonic_ranger_core.sv
// Scoreboard bench for ultrasonic_ranger_core with scaled-down timing.
module tb_ultrasonic_ranger_core;

   localparam int CLK_HZ = 2_000_000;
   localparam int DIV    = CLK_HZ / 1_000_000;
   localparam int TRG_US = 10;
   localparam int TO_US  = 2000;
   localparam int HO_US  = 200;

   logic        ACLK = 1'b0;
   logic        ARESETN = 1'b0;
   logic        start = 1'b0;
   logic        auto_en = 1'b0;
   logic        echo = 1'b0;
   logic        trig;
   logic        busy;
   logic        valid;
   logic        timeout;
   logic [15:0] echo_us;
   logic [9:0]  distance_cm;
   logic [15:0] meas_count;

   typedef struct {
      int to;
      int us;
      int cm;
      int cnt;
   } exp_t;

   exp_t q[$];
   int   n_tests = 0;
   int   n_fail = 0;
   int   exp_cnt = 0;
   int   cyc = 0;

   ultrasonic_ranger_core #(
      .CLK_FREQ_HZ(CLK_HZ),
      .TRIG_US    (TRG_US),
      .TIMEOUT_US (TO_US),
      .HOLDOFF_US (HO_US)
   ) dut (
      .ACLK       (ACLK),
      .ARESETN    (ARESETN),
      .start      (start),
      .auto_en    (auto_en),
      .echo       (echo),
      .trig       (trig),
      .busy       (busy),
      .valid      (valid),
      .timeout    (timeout),
      .echo_us    (echo_us),
      .distance_cm(distance_cm),
      .meas_count (meas_count)
   );

   initial forever #5 ACLK = ~ACLK;
   initial forever begin
      @(posedge ACLK);
      cyc++;
   end

   task automatic chk(input string nm, input int act, input int exp);
      n_tests++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", nm, act, exp);
      end
   endtask

   task automatic chk_rng(input string nm, input int act,
                          input int lo, input int hi);
      n_tests++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d..%0d", nm, act, lo, hi);
      end
   endtask

   task automatic push(input int to, input int us, input int cm);
      exp_t e;
      exp_cnt++;
      e.to  = to;
      e.us  = us;
      e.cm  = cm;
      e.cnt = exp_cnt;
      q.push_back(e);
   endtask

   // Monitor: every valid strobe must match the oldest expectation.
   initial forever begin
      @(negedge ACLK);
      if (valid) begin
         if (q.size() == 0) begin
            chk("unexpected_valid", 1, 0);
         end else begin
            exp_t e;
            e = q.pop_front();
            chk("timeout", int'(timeout), e.to);
            chk("echo_us", int'(echo_us), e.us);
            chk("distance_cm", int'(distance_cm), e.cm);
            chk("meas_count", int'(meas_count), e.cnt);
         end
      end
   end

   task automatic pulse_start();
      @(negedge ACLK);
      start = 1'b1;
      @(negedge ACLK);
      start = 1'b0;
   endtask

   task automatic wait_rise(output int t);
      int i;
      i = 0;
      while (!trig && i < 4000) begin
         @(negedge ACLK);
         i++;
      end
      if (!trig) chk("trig_rise_seen", int'(trig), 1);
      t = cyc;
   endtask

   task automatic wait_fall(output int w);
      w = 0;
      while (trig && w < 1000) begin
         @(negedge ACLK);
         w++;
      end
   endtask

   task automatic echo_pulse(input int us);
      repeat (50 * DIV) @(negedge ACLK);
      echo = 1'b1;
      repeat (us * DIV) @(negedge ACLK);
      echo = 1'b0;
   endtask

   task automatic wait_idle();
      int i;
      i = 0;
      while ((busy || q.size() != 0) && i < 20000) begin
         @(negedge ACLK);
         i++;
      end
      chk("back_to_idle", int'(busy), 0);
      chk("pending_results", q.size(), 0);
   endtask

   task automatic shot(input int us, input int cm);
      int t;
      int w;
      pulse_start();
      wait_rise(t);
      wait_fall(w);
      chk("trig_width", w, TRG_US * DIV);
      push(0, us, cm);
      echo_pulse(us);
      wait_idle();
   endtask

   initial begin
      int t0;
      int t1;
      int w;
      int c;
      t0 = 0;
      repeat (3) @(negedge ACLK);
      chk("rst_trig", int'(trig), 0);
      chk("rst_busy", int'(busy), 0);
      chk("rst_valid", int'(valid), 0);
      chk("rst_timeout", int'(timeout), 0);
      chk("rst_echo_us", int'(echo_us), 0);
      chk("rst_distance", int'(distance_cm), 0);
      chk("rst_count", int'(meas_count), 0);
      ARESETN = 1'b1;

      shot(1160, 20);
      shot(579, 9);
      shot(580, 10);

      pulse_start();
      wait_rise(t1);
      wait_fall(w);
      push(1, TO_US, 1023);
      c = 0;
      while (!valid && c < 6000) begin
         @(negedge ACLK);
         c++;
      end
      chk_rng("rise_timeout_latency", c, TO_US * DIV - 3, TO_US * DIV + 3);
      wait_idle();

      shot(1160, 20);

      echo = 1'b1;
      pulse_start();
      wait_rise(t1);
      wait_fall(w);
      push(1, TO_US, 1023);
      wait_idle();
      echo = 1'b0;

      pulse_start();
      wait_rise(t1);
      wait_fall(w);
      push(1, TO_US, 1023);
      repeat (50 * DIV) @(negedge ACLK);
      echo = 1'b1;
      c = 0;
      while (!valid && c < 6000) begin
         @(negedge ACLK);
         c++;
      end
      chk_rng("high_timeout_latency", c, TO_US * DIV - 1, TO_US * DIV + 5);
      repeat (2500 * DIV - c) @(negedge ACLK);
      echo = 1'b0;
      wait_idle();

      @(negedge ACLK);
      auto_en = 1'b1;
      for (int k = 0; k < 3; k++) begin
         wait_rise(t1);
         if (k > 0) chk_rng("auto_period", t1 - t0,
                            (TRG_US + 50 + 1160 + HO_US) * DIV,
                            (TRG_US + 50 + 1160 + HO_US) * DIV + 6);
         t0 = t1;
         wait_fall(w);
         chk("auto_trig_width", w, TRG_US * DIV);
         if (k == 2) begin
            auto_en = 1'b0;
            start = 1'b1;
            @(negedge ACLK);
            start = 1'b0;
         end
         push(0, 1160, 20);
         echo_pulse(1160);
      end
      wait_idle();
      c = 0;
      repeat (200) begin
         @(negedge ACLK);
         if (trig || busy) c++;
      end
      chk("stays_idle", c, 0);

      pulse_start();
      wait_rise(t1);
      wait_fall(w);
      repeat (50 * DIV) @(negedge ACLK);
      echo = 1'b1;
      repeat (600) @(negedge ACLK);
      #2 ARESETN = 1'b0;
      #1;
      chk("mrst_trig", int'(trig), 0);
      chk("mrst_busy", int'(busy), 0);
      chk("mrst_valid", int'(valid), 0);
      chk("mrst_echo_us", int'(echo_us), 0);
      chk("mrst_distance", int'(distance_cm), 0);
      chk("mrst_count", int'(meas_count), 0);
      exp_cnt = 0;
      echo = 1'b0;
      repeat (3) @(negedge ACLK);
      ARESETN = 1'b1;

      pulse_start();
      wait_rise(t1);
      #2 ARESETN = 1'b0;
      #1;
      chk("trst_trig", int'(trig), 0);
      chk("trst_busy", int'(busy), 0);
      @(negedge ACLK);
      ARESETN = 1'b1;

      shot(1160, 20);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
